// File: rtl/cu_mem_arbiter.sv
// Round-robin arbiter that shares one memory read/write port among num_cu compute units.
// One transaction is in flight at a time, and a watchdog aborts transactions that get no response.
module cu_mem_arbiter #(
    parameter int num_cu         = 4,
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int timeout_cycles = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [num_cu-1:0]            cu_read_req,
    input  logic [num_cu*addr_width-1:0] cu_read_addr,
    output logic [num_cu-1:0]            cu_read_valid,
    output logic [data_width-1:0]        cu_read_data,
    input  logic [num_cu-1:0]            cu_write_req,
    input  logic [num_cu*addr_width-1:0] cu_write_addr,
    input  logic [num_cu*data_width-1:0] cu_write_data,
    output logic [num_cu-1:0]            cu_write_ack,
    output logic                         mem_read_req,
    output logic [addr_width-1:0]        mem_read_addr,
    input  logic                         mem_read_valid,
    input  logic [data_width-1:0]        mem_read_data,
    output logic                         mem_write_req,
    output logic [addr_width-1:0]        mem_write_addr,
    output logic [data_width-1:0]        mem_write_data,
    input  logic                         mem_write_ack,
    output logic                         busy,
    output logic [$clog2(num_cu)-1:0]    grant_id,
    output logic                         timeout_err,
    output logic [$clog2(num_cu)-1:0]    timeout_id
);

    localparam int id_w  = $clog2(num_cu);
    localparam int cnt_w = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam bit wdog_en = (timeout_cycles > 0);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);
    localparam logic [id_w:0]    num_cu_w = (id_w + 1)'(num_cu);
    localparam logic [id_w-1:0]  last_id  = id_w'(num_cu - 1);

    // Each wait state owns one state bit, so the downstream requests come straight from flops.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        WR_WAIT = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [id_w-1:0]  rr_ptr;
    logic [id_w-1:0]  winner;
    logic             any_req;
    logic [num_cu-1:0] eligible;
    logic [cnt_w-1:0] wait_cnt;
    logic             resp;
    logic             expired;

    assign eligible      = cu_read_req | cu_write_req;
    assign mem_read_req  = state[0];
    assign mem_write_req = state[1];
    assign busy          = (state != IDLE);

    assign resp    = (state == RD_WAIT && mem_read_valid) || (state == WR_WAIT && mem_write_ack);
    assign expired = wdog_en && (state != IDLE) && (wait_cnt == cnt_last) && !resp;

    // First eligible unit at or above rr_ptr, wrapping past num_cu-1.
    always_comb begin : arb_search
        logic [id_w:0] idx;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int k = 0; k < num_cu; k++) begin
            idx = {1'b0, rr_ptr} + (id_w + 1)'(k);
            if (idx >= num_cu_w) begin
                idx = idx - num_cu_w;
            end
            if (!any_req && eligible[idx[id_w-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[id_w-1:0];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        cu_read_valid = '0;
        cu_write_ack  = '0;
        cu_read_data  = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = cu_read_req[winner] ? RD_WAIT : WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_read_valid) begin
                    cu_read_valid[grant_id] = 1'b1;
                    cu_read_data            = mem_read_data;
                    state_nxt               = IDLE;
                end else if (expired) begin
                    state_nxt = IDLE;
                end
            end
            WR_WAIT: begin
                if (mem_write_ack) begin
                    cu_write_ack[grant_id] = 1'b1;
                    state_nxt              = IDLE;
                end else if (expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            grant_id       <= '0;
            wait_cnt       <= '0;
            mem_read_addr  <= '0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            timeout_err    <= 1'b0;
            timeout_id     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                wait_cnt <= '0;
                if (any_req) begin
                    grant_id <= winner;
                    rr_ptr   <= (winner == last_id) ? '0 : winner + id_w'(1);
                    if (cu_read_req[winner]) begin
                        mem_read_addr <= cu_read_addr[int'(winner)*addr_width +: addr_width];
                    end else begin
                        mem_write_addr <= cu_write_addr[int'(winner)*addr_width +: addr_width];
                        mem_write_data <= cu_write_data[int'(winner)*data_width +: data_width];
                    end
                end
            end else begin
                wait_cnt <= wait_cnt + cnt_w'(1);
            end
            if (expired) begin
                timeout_err <= 1'b1;
                if (!timeout_err) begin
                    timeout_id <= grant_id;
                end
            end
        end
    end

endmodule
